// File: rtl/vga_frame_reader.sv
// VGA scan-out engine: timing generation, frame-buffer fetch with integer up-scaling,
// frame skip after enable and optional double buffering. All outputs share one pipeline delay.
//
// state  | meaning
// S_IDLE | scan-out off, syncs running, screen black
// S_SKIP | enabled, discarding whole frames until the skip count is reached
// S_RUN  | frame buffer is read and displayed
module vga_frame_reader #(
    parameter int H_DISP      = 640,
    parameter int H_FP        = 16,
    parameter int H_PULSE     = 96,
    parameter int H_BP        = 48,
    parameter int V_DISP      = 480,
    parameter int V_FP        = 10,
    parameter int V_PULSE     = 2,
    parameter int V_BP        = 33,
    parameter int PIX_W       = 9,
    parameter int SCALE_SHIFT = 0,
    parameter int RD_LAT      = 1,
    parameter int SKIP_FRAMES = 2,
    parameter int DOUBLE_BUF  = 0,
    parameter int ADDR_W      = 19
) (
    input  logic                 i_clk25m,
    input  logic                 i_rst_clk25m,
    input  logic                 i_enable,
    input  logic                 i_buf_sel,
    input  logic [PIX_W-1:0]     i_pix_data,
    output logic [ADDR_W-1:0]    o_pix_addr,
    output logic                 o_pix_rd,
    output logic [9:0]           o_VGA_x,
    output logic [9:0]           o_VGA_y,
    output logic                 o_VGA_hsync,
    output logic                 o_VGA_vsync,
    output logic                 o_VGA_video,
    output logic [PIX_W/3-1:0]   o_VGA_red,
    output logic [PIX_W/3-1:0]   o_VGA_green,
    output logic [PIX_W/3-1:0]   o_VGA_blue,
    output logic                 o_frame_start
);

    localparam int H_TOT   = H_DISP + H_FP + H_PULSE + H_BP;
    localparam int V_TOT   = V_DISP + V_FP + V_PULSE + V_BP;
    localparam int FB_W    = H_DISP >> SCALE_SHIFT;
    localparam int FB_H    = V_DISP >> SCALE_SHIFT;
    localparam int FB_SIZE = FB_W * FB_H;
    localparam int LAT     = RD_LAT + 2;
    localparam int SKIP_W  = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;
    localparam int SUB_W   = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
    localparam int MW      = 24;
    localparam int SR_W    = LAT * MW;

    localparam logic [9:0]        Y_MASK    = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [SUB_W-1:0]  SUB_MAX   = SUB_W'((1 << SCALE_SHIFT) - 1);
    localparam logic [ADDR_W-1:0] FB_W_A    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] FB_SIZE_A = ADDR_W'(FB_SIZE);

    typedef enum logic [1:0] {S_IDLE, S_SKIP, S_RUN} state_t;

    typedef struct packed {
        logic       fs;
        logic       video;
        logic       vsync;
        logic       hsync;
        logic [9:0] y;
        logic [9:0] x;
    } meta_t;

    localparam meta_t META_RST = '{fs: 1'b0, video: 1'b0, vsync: 1'b1, hsync: 1'b1, y: 10'd0, x: 10'd0};

    logic [9:0]        cnt_x, cnt_y;
    logic              line_end, frame_end;
    logic              raw_hsync, raw_vsync, raw_video;
    state_t            state, state_nxt;
    logic [SKIP_W-1:0] skip_cnt, skip_cnt_nxt;
    logic              running;
    logic [ADDR_W-1:0] base, base_nxt, row_base, col;
    logic [SUB_W-1:0]  sub;
    logic [RD_LAT-1:0] rd_dly;
    meta_t             meta_raw, meta_out;
    logic [SR_W-1:0]   meta_sr;

    assign line_end  = (cnt_x == 10'(H_TOT - 1));
    assign frame_end = line_end && (cnt_y == 10'(V_TOT - 1));

    always_ff @(posedge i_clk25m or posedge i_rst_clk25m) begin
        if (i_rst_clk25m) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (line_end) begin
            cnt_x <= '0;
            cnt_y <= (cnt_y == 10'(V_TOT - 1)) ? '0 : cnt_y + 10'd1;
        end else begin
            cnt_x <= cnt_x + 10'd1;
        end
    end

    always_comb begin
        raw_hsync = !((cnt_x >= 10'(H_DISP + H_FP)) && (cnt_x <= 10'(H_DISP + H_FP + H_PULSE - 1)));
        raw_vsync = !((cnt_y >= 10'(V_DISP + V_FP)) && (cnt_y <= 10'(V_DISP + V_FP + V_PULSE - 1)));
        raw_video = (cnt_x < 10'(H_DISP)) && (cnt_y < 10'(V_DISP));
    end

    always_ff @(posedge i_clk25m or posedge i_rst_clk25m) begin
        if (i_rst_clk25m) begin
            state    <= S_IDLE;
            skip_cnt <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_cnt_nxt;
        end
    end

    // Decisions are taken only at frame end so every displayed frame is whole.
    always_comb begin
        state_nxt    = state;
        skip_cnt_nxt = skip_cnt;
        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (i_enable) begin
                        if (SKIP_FRAMES == 0) begin
                            state_nxt = S_RUN;
                        end else begin
                            state_nxt    = S_SKIP;
                            skip_cnt_nxt = '0;
                        end
                    end
                end
                S_SKIP: begin
                    if (!i_enable)
                        state_nxt = S_IDLE;
                    else if (skip_cnt == SKIP_W'(SKIP_FRAMES - 1))
                        state_nxt = S_RUN;
                    else
                        skip_cnt_nxt = skip_cnt + 1'b1;
                end
                S_RUN: begin
                    if (!i_enable)
                        state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == S_RUN);
    end

    assign base_nxt = ((DOUBLE_BUF != 0) && i_buf_sel) ? FB_SIZE_A : '0;

    // Incremental address walk: a line is re-read until its last replicated copy.
    always_ff @(posedge i_clk25m or posedge i_rst_clk25m) begin
        if (i_rst_clk25m) begin
            base     <= '0;
            row_base <= '0;
            col      <= '0;
            sub      <= '0;
        end else if (frame_end) begin
            base     <= base_nxt;
            row_base <= base_nxt;
            col      <= '0;
            sub      <= '0;
        end else if (raw_video) begin
            if (cnt_x == 10'(H_DISP - 1)) begin
                col <= '0;
                sub <= '0;
                if ((cnt_y & Y_MASK) == Y_MASK)
                    row_base <= row_base + FB_W_A;
            end else if (sub == SUB_MAX) begin
                sub <= '0;
                col <= col + 1'b1;
            end else begin
                sub <= sub + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk25m or posedge i_rst_clk25m) begin
        if (i_rst_clk25m) begin
            o_pix_addr <= '0;
            o_pix_rd   <= 1'b0;
            rd_dly     <= '0;
        end else begin
            o_pix_addr <= row_base + col;
            o_pix_rd   <= running && raw_video;
            rd_dly     <= RD_LAT'({rd_dly, o_pix_rd});
        end
    end

    always_ff @(posedge i_clk25m or posedge i_rst_clk25m) begin
        if (i_rst_clk25m)
            {o_VGA_red, o_VGA_green, o_VGA_blue} <= '0;
        else if (rd_dly[RD_LAT-1])
            {o_VGA_red, o_VGA_green, o_VGA_blue} <= i_pix_data;
        else
            {o_VGA_red, o_VGA_green, o_VGA_blue} <= '0;
    end

    always_comb begin
        meta_raw.fs    = running && (cnt_x == 10'd0) && (cnt_y == 10'd0);
        meta_raw.video = raw_video;
        meta_raw.vsync = raw_vsync;
        meta_raw.hsync = raw_hsync;
        meta_raw.y     = cnt_y;
        meta_raw.x     = cnt_x;
    end

    // Timing metadata travels alongside the read so the pins describe one pixel.
    always_ff @(posedge i_clk25m or posedge i_rst_clk25m) begin
        if (i_rst_clk25m)
            meta_sr <= {LAT{META_RST}};
        else
            meta_sr <= SR_W'({meta_sr, meta_raw});
    end

    assign meta_out      = meta_sr[SR_W-1 -: MW];
    assign o_VGA_x       = meta_out.x;
    assign o_VGA_y       = meta_out.y;
    assign o_VGA_hsync   = meta_out.hsync;
    assign o_VGA_vsync   = meta_out.vsync;
    assign o_VGA_video   = meta_out.video;
    assign o_frame_start = meta_out.fs;

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader: two reduced-timing instances (S=0/RD_LAT=1 and
// S=1/RD_LAT=3/double buffer) against a frame-level reference model.
module tb_vga_frame_reader;

    localparam int H_DISP = 16, H_FP = 2, H_PULSE = 3, H_BP = 3;
    localparam int V_DISP = 8,  V_FP = 1, V_PULSE = 2, V_BP = 1;
    localparam int H_TOT  = H_DISP + H_FP + H_PULSE + H_BP;
    localparam int V_TOT  = V_DISP + V_FP + V_PULSE + V_BP;
    localparam int FR     = H_TOT * V_TOT;
    localparam int ADDR_W = 8;

    localparam int S_C[2]  = '{0, 1};
    localparam int RL_C[2] = '{1, 3};
    localparam int SK_C[2] = '{2, 1};
    localparam int DB_C[2] = '{0, 1};
    localparam int PW_C[2] = '{9, 12};

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       vid;
        logic       fs;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } exp_t;

    typedef struct packed {
        logic              rd;
        logic [ADDR_W-1:0] addr;
    } aexp_t;

    localparam exp_t RST_E = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, vid: 1'b0,
                               fs: 1'b0, r: 4'd0, g: 4'd0, b: 4'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic bsel = 1'b0;

    always #5 clk = ~clk;

    logic [8:0]        pd0;
    logic [ADDR_W-1:0] pa0;
    logic              rd0, hs0, vs0, vid0, fs0;
    logic [9:0]        x0, y0;
    logic [2:0]        r0, g0, b0;

    logic [11:0]       pd1;
    logic [ADDR_W-1:0] pa1;
    logic              rd1, hs1, vs1, vid1, fs1;
    logic [9:0]        x1, y1;
    logic [3:0]        r1, g1, b1;

    vga_frame_reader #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_PULSE(H_PULSE), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_PULSE(V_PULSE), .V_BP(V_BP),
        .PIX_W(9), .SCALE_SHIFT(0), .RD_LAT(1), .SKIP_FRAMES(2),
        .DOUBLE_BUF(0), .ADDR_W(ADDR_W)
    ) dut0 (
        .i_clk25m(clk), .i_rst_clk25m(rst), .i_enable(en), .i_buf_sel(bsel),
        .i_pix_data(pd0), .o_pix_addr(pa0), .o_pix_rd(rd0),
        .o_VGA_x(x0), .o_VGA_y(y0), .o_VGA_hsync(hs0), .o_VGA_vsync(vs0),
        .o_VGA_video(vid0), .o_VGA_red(r0), .o_VGA_green(g0), .o_VGA_blue(b0),
        .o_frame_start(fs0)
    );

    vga_frame_reader #(
        .H_DISP(H_DISP), .H_FP(H_FP), .H_PULSE(H_PULSE), .H_BP(H_BP),
        .V_DISP(V_DISP), .V_FP(V_FP), .V_PULSE(V_PULSE), .V_BP(V_BP),
        .PIX_W(12), .SCALE_SHIFT(1), .RD_LAT(3), .SKIP_FRAMES(1),
        .DOUBLE_BUF(1), .ADDR_W(ADDR_W)
    ) dut1 (
        .i_clk25m(clk), .i_rst_clk25m(rst), .i_enable(en), .i_buf_sel(bsel),
        .i_pix_data(pd1), .o_pix_addr(pa1), .o_pix_rd(rd1),
        .o_VGA_x(x1), .o_VGA_y(y1), .o_VGA_hsync(hs1), .o_VGA_vsync(vs1),
        .o_VGA_video(vid1), .o_VGA_red(r1), .o_VGA_green(g1), .o_VGA_blue(b1),
        .o_frame_start(fs1)
    );

    // Frame-buffer BRAMs: content is a fixed function of the address, latency RD_LAT.
    function automatic logic [11:0] mem_word(input logic [ADDR_W-1:0] a);
        return 12'(int'(a) * 5 + 1);
    endfunction

    logic [ADDR_W-1:0] ap0;
    logic [ADDR_W-1:0] ap1 [3];

    always @(posedge clk) begin
        ap0    <= pa0;
        ap1[0] <= pa1;
        ap1[1] <= ap1[0];
        ap1[2] <= ap1[1];
    end

    assign pd0 = 9'(mem_word(ap0));
    assign pd1 = mem_word(ap1[2]);

    exp_t  got0, got1;
    aexp_t ag0, ag1;
    assign got0 = {x0, y0, hs0, vs0, vid0, fs0, 1'b0, r0, 1'b0, g0, 1'b0, b0};
    assign got1 = {x1, y1, hs1, vs1, vid1, fs1, r1, g1, b1};
    assign ag0  = {rd0, pa0};
    assign ag1  = {rd1, pa1};

    exp_t  q0[$], q1[$];
    aexp_t aq0[$], aq1[$];

    int n_checks = 0;
    int n_fails  = 0;

    int m_n;
    int m_consec [2];
    bit m_disp   [2];
    int m_base   [2];

    task automatic model_reset();
        m_n = 0;
        q0.delete(); q1.delete(); aq0.delete(); aq1.delete();
        for (int c = 0; c < 2; c++) begin
            m_consec[c] = 0;
            m_disp[c]   = 1'b0;
            m_base[c]   = 0;
        end
        repeat (RL_C[0] + 1) q0.push_back(RST_E);
        repeat (RL_C[1] + 1) q1.push_back(RST_E);
    endtask

    // Expected view of pixel number m_n for one configuration, pushed at the counter stage.
    task automatic model_step(input int c);
        int    x, y, s, addr, data, pw, cw, msk;
        bit    rdv;
        exp_t  e;
        aexp_t a;
        s   = S_C[c];
        x   = m_n % H_TOT;
        y   = (m_n / H_TOT) % V_TOT;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.hs  = !(x >= H_DISP + H_FP && x < H_DISP + H_FP + H_PULSE);
        e.vs  = !(y >= V_DISP + V_FP && y < V_DISP + V_FP + V_PULSE);
        e.vid = (x < H_DISP) && (y < V_DISP);
        e.fs  = m_disp[c] && x == 0 && y == 0;
        rdv   = m_disp[c] && e.vid;
        addr  = m_base[c] + (y >> s) * (H_DISP >> s) + (x >> s);
        pw    = PW_C[c];
        cw    = pw / 3;
        msk   = (1 << cw) - 1;
        data  = int'(mem_word(ADDR_W'(addr))) & ((1 << pw) - 1);
        e.r   = rdv ? 4'((data >> (2 * cw)) & msk) : 4'd0;
        e.g   = rdv ? 4'((data >> cw) & msk) : 4'd0;
        e.b   = rdv ? 4'(data & msk) : 4'd0;
        a.rd   = rdv;
        a.addr = ADDR_W'(addr);
        if (c == 0) begin q0.push_back(e); aq0.push_back(a); end
        else        begin q1.push_back(e); aq1.push_back(a); end
        if (x == H_TOT - 1 && y == V_TOT - 1) begin
            m_consec[c] = en ? m_consec[c] + 1 : 0;
            m_disp[c]   = m_consec[c] >= SK_C[c] + 1;
            m_base[c]   = (DB_C[c] != 0 && bsel) ? (H_DISP >> s) * (V_DISP >> s) : 0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                model_reset();
            end else begin
                model_step(0);
                model_step(1);
                m_n++;
            end
        end
    end

    task automatic mon_cfg(input int c, input exp_t got, input aexp_t ag);
        exp_t  e;
        aexp_t a;
        bit    empty;
        if (rst) begin
            n_checks++;
            if (got !== RST_E || ag !== '0) begin
                n_fails++;
                $display("FAIL cfg%0d reset_values t=%0t got=%h/%h required=%h/%h",
                         c, $time, got, ag, RST_E, aexp_t'(0));
            end
        end else begin
            empty = (c == 0) ? (q0.size() == 0 || aq0.size() == 0)
                             : (q1.size() == 0 || aq1.size() == 0);
            if (empty) begin
                n_checks++;
                n_fails++;
                $display("FAIL cfg%0d scoreboard_empty t=%0t got=%h required=entry", c, $time, got);
            end else begin
                if (c == 0) begin e = q0.pop_front(); a = aq0.pop_front(); end
                else        begin e = q1.pop_front(); a = aq1.pop_front(); end
                n_checks++;
                if (got !== e) begin
                    n_fails++;
                    $display("FAIL cfg%0d pixel t=%0t got x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b rgb=%h%h%h required x=%0d y=%0d hs=%b vs=%b vid=%b fs=%b rgb=%h%h%h",
                             c, $time, got.x, got.y, got.hs, got.vs, got.vid, got.fs, got.r, got.g, got.b,
                             e.x, e.y, e.hs, e.vs, e.vid, e.fs, e.r, e.g, e.b);
                end
                n_checks++;
                if (ag.rd !== a.rd || (a.rd && ag.addr !== a.addr)) begin
                    n_fails++;
                    $display("FAIL cfg%0d bram_read t=%0t got rd=%b addr=%0d required rd=%b addr=%0d",
                             c, $time, ag.rd, ag.addr, a.rd, a.addr);
                end
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_cfg(0, got0, ag0);
            mon_cfg(1, got1, ag1);
        end
    end

    task automatic step(input int ncyc, input int p_en, input int p_bs);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            #1;
            if (p_en > 0 && $urandom_range(0, 999) < p_en) en = ~en;
            if ($urandom_range(0, 999) < p_bs) bsel = ~bsel;
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        en  = 1'b1;
        step(FR * 5 + 100, 0, 8);
        en = 1'b0;
        step(FR * 2, 0, 8);
        en = 1'b1;
        step(FR * 4 + 37, 0, 8);
        rst = 1'b1;
        step(3, 0, 0);
        rst = 1'b0;
        step(FR * 4, 0, 8);
        step(FR * 6, 4, 10);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Parametrised VGA scan-out engine for the 25 MHz display domain: generates VGA timing, fetches pixels from the frame-buffer BRAM, and drives sync, video and RGB outputs. All outputs are aligned to the BRAM read latency. Generalises the fixed 640x480 / 9-bit reader with:

- configurable timing and pixel width;
- integer up-scaling from a smaller frame buffer;
- configurable frame skip;
- double buffering.

## Interface
- H_DISP, H_FP, H_PULSE, H_BP: 640, 16, 96, 48. Horizontal timing in pixels.
- V_DISP, V_FP, V_PULSE, V_BP: 480, 10, 2, 33. Vertical timing in lines.
- PIX_W: 9. BRAM pixel width, multiple of 3. Packed as R in the MSBs, then G, then B.
- SCALE_SHIFT: 0. Frame buffer is (H_DISP>>S) x (V_DISP>>S); each stored pixel is replicated 2^S x 2^S. Legal values 0..2.
- RD_LAT: 1. BRAM read latency in cycles, 1..3.
- SKIP_FRAMES: 2. Whole frames discarded after enable before reading.
- DOUBLE_BUF: 0. When 1, the second buffer starts at address FB_SIZE.
- ADDR_W: 19. Address width. Requires (1+DOUBLE_BUF)*FB_SIZE <= 2^ADDR_W.
- i_clk25m: input, 1. Pixel clock.
- i_rst_clk25m: input, 1. Reset, asynchronous and active-high.
- i_enable: input, 1. Scan-out request.
- i_buf_sel: input, 1. Buffer to display. Ignored when DOUBLE_BUF=0.
- i_pix_data: input, PIX_W. BRAM read data.
- o_pix_addr: output, ADDR_W. BRAM read address (registered).
- o_pix_rd: output, 1. BRAM read enable.
- o_VGA_x, o_VGA_y: output, 10 each. Pixel coordinates, aligned with RGB.
- o_VGA_hsync, o_VGA_vsync: output, 1 each. Active-low syncs, aligned with RGB.
- o_VGA_video: output, 1. Active-region flag, aligned with RGB.
- o_VGA_red, o_VGA_green, o_VGA_blue: output, PIX_W/3 each. Registered colour.
- o_frame_start: output, 1. One-cycle pulse with output pixel (0,0) of every displayed frame.

## Operation
- Derived constants:
  - H_TOT = H_DISP+H_FP+H_PULSE+H_BP (800); V_TOT likewise (525).
  - FB_W = H_DISP>>S; FB_H = V_DISP>>S; FB_SIZE = FB_W*FB_H (307200 at defaults).
- Counters: x runs 0..H_TOT-1 and wraps. y increments when x wraps, and wraps at V_TOT-1. Frame end (FE) is x=H_TOT-1 and y=V_TOT-1.
- Sync and video (raw, at counter stage):
  - hsync is low for x in [H_DISP+H_FP, H_DISP+H_FP+H_PULSE-1] ([656,751] at defaults).
  - vsync is low for y in [V_DISP+V_FP, V_DISP+V_FP+V_PULSE-1] ([490,491]).
  - video = (x<H_DISP) && (y<V_DISP).
- State machine (all transitions only at FE, so every displayed frame is whole):
  - IDLE: if i_enable, go to SKIP with skip count 0. If SKIP_FRAMES=0, go directly to RUN.
  - SKIP: increment the count at each FE. When count = SKIP_FRAMES-1, go to RUN. If i_enable is low, go to IDLE.
  - RUN: if i_enable is low, go to IDLE; otherwise stay in RUN.
- Buffer base: latched at each FE from i_buf_sel, where base = i_buf_sel ? FB_SIZE : 0. It never changes mid-frame.
- Address generation, no multiplier:
  - row_base and col are updated incrementally.
  - col advances every 2^S active pixels.
  - At the end of each active line, col resets. row_base += FB_W only when y[S-1:0] is all ones; otherwise the line is re-read.
  - At FE, row_base = base.
  - o_pix_addr = row_base + col, registered.
  - o_pix_rd = RUN && raw video, registered alongside the address.
- Colour: RGB = i_pix_data fields when the delayed rd is set, else 0. Outside RUN the screen is black but syncs run.

## Timing
- Reset values:
  - counters 0, state IDLE, skip count 0, base 0;
  - o_pix_addr 0, o_pix_rd 0;
  - RGB 0, o_VGA_video 0, o_frame_start 0;
  - o_VGA_hsync 1, o_VGA_vsync 1;
  - o_VGA_x 0, o_VGA_y 0.
- Pipeline (LAT = RD_LAT+2):
  - counter stage at cycle t;
  - address and rd at t+1;
  - data at t+1+RD_LAT;
  - RGB register at t+2+RD_LAT.
- x, y, hsync, vsync, video and frame_start are delayed through an LAT-deep shift register, so all outputs describe the same pixel.
- Reset asserted mid-frame clears everything asynchronously. After release, the first FE restarts the skip sequence.
- A buffer-select or enable change less than one cycle before FE takes effect at the next FE.

## Test plan
- Reset, defaults, i_enable=1: hsync low exactly 96 cycles every 800; vsync low for lines 490-491; first o_pix_rd only after 3 FEs (IDLE→SKIP→SKIP→RUN); RGB 0 before that.
- RUN, RD_LAT=1, BRAM model data = address[8:0]: output pixel (x,y) has RGB = (y*640+x)[8:0]; o_pix_addr reaches 307199 at (639,479); o_frame_start coincides with output (0,0).
- SCALE_SHIFT=1, FB 320x240: lines 0 and 1 both read addresses 0..319, each address held 2 cycles; line 2 starts at 320; last address is 76799.
- DOUBLE_BUF=1, S=1: i_buf_sel toggled mid-frame → addresses change to the 76800 base only from the next frame's first pixel.
- i_enable dropped mid-frame → the current frame completes, then black from the next frame with syncs unchanged; re-enable → SKIP_FRAMES whole frames skipped again.
- RD_LAT=3: the sync/video/RGB relationship is unchanged; latency from counter to pins is 5 cycles.
